// File: rtl/cv32e40p_pkg.sv
// Shared types for the CV32E40P instruction-fetch path.
// Holds the OBI instruction interface FSM state encoding.
package cv32e40p_pkg;

  typedef enum logic {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } obi_if_state_e;

endpackage

// File: rtl/cv32e40p_instr_obi_if.sv
// OBI instruction-fetch interface: forwards prefetch requests to OBI, holds the address stable
// while an accepted request waits for grant, and filters responses made stale by kill_i.
module cv32e40p_instr_obi_if
  import cv32e40p_pkg::*;
#(
  parameter int unsigned PULP_OBI        = 0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [31:0] trans_addr_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o
);

  localparam logic [1:0] MAX_OUT = MAX_OUTSTANDING[1:0];

  obi_if_state_e state_r, state_nxt_s;
  logic [31:0]   addr_r, addr_nxt_s;
  logic [1:0]    outstanding_r, outstanding_nxt_s;
  logic [1:0]    discard_r, discard_nxt_s;
  logic          stale_r, stale_nxt_s;
  logic          room_s, req_gnt_s, reg_gnt_s, drop_s;

  assign room_s    = (outstanding_r < MAX_OUT);
  assign req_gnt_s = obi_req_o & obi_gnt_i;
  assign reg_gnt_s = (state_r == REGISTERED) & obi_gnt_i;
  assign drop_s    = obi_rvalid_i & (discard_r != 2'd0);

  // Request-side FSM: next state, OBI request/address and prefetcher handshake.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    obi_req_o     = 1'b0;
    obi_addr_o    = trans_addr_i;
    trans_ready_o = 1'b0;
    case (state_r)
      TRANSPARENT: begin
        obi_req_o  = trans_valid_i & ~kill_i & room_s;
        obi_addr_o = trans_addr_i;
        if (PULP_OBI != 32'd0) begin
          trans_ready_o = obi_req_o & obi_gnt_i;
        end else begin
          trans_ready_o = ~kill_i & room_s;
          // An accepted but ungranted request must keep its address until granted.
          if (trans_valid_i && trans_ready_o && !obi_gnt_i) begin
            state_nxt_s = REGISTERED;
            addr_nxt_s  = trans_addr_i;
          end else begin
            state_nxt_s = TRANSPARENT;
          end
        end
      end
      REGISTERED: begin
        obi_req_o     = 1'b1;
        obi_addr_o    = addr_r;
        trans_ready_o = 1'b0;
        if (obi_gnt_i) begin
          state_nxt_s = TRANSPARENT;
        end else begin
          state_nxt_s = REGISTERED;
        end
      end
      default: begin
        state_nxt_s = TRANSPARENT;
      end
    endcase
  end

  // Outstanding-transaction and stale-response bookkeeping.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    discard_nxt_s     = discard_r;
    stale_nxt_s       = stale_r;
    if (req_gnt_s && !obi_rvalid_i) begin
      outstanding_nxt_s = outstanding_r + 2'd1;
    end else if (!req_gnt_s && obi_rvalid_i) begin
      outstanding_nxt_s = outstanding_r - 2'd1;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
    // A response coinciding with kill is retired here rather than discarded later.
    if (kill_i) begin
      discard_nxt_s = outstanding_r - {1'b0, obi_rvalid_i} + {1'b0, reg_gnt_s};
      stale_nxt_s   = (state_r == REGISTERED) & ~obi_gnt_i;
    end else begin
      discard_nxt_s = discard_r - {1'b0, drop_s} + {1'b0, stale_r & reg_gnt_s};
      stale_nxt_s   = stale_r & ~reg_gnt_s;
    end
  end

  assign resp_valid_o = obi_rvalid_i & ~kill_i & (discard_r == 2'd0);
  assign resp_rdata_o = obi_rdata_i;
  assign resp_err_o   = obi_err_i;
  assign busy_o       = (outstanding_r != 2'd0) | (state_r == REGISTERED);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= TRANSPARENT;
      addr_r        <= 32'd0;
      outstanding_r <= 2'd0;
      discard_r     <= 2'd0;
      stale_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      addr_r        <= addr_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      stale_r       <= stale_nxt_s;
    end
  end

`ifdef CV32E40P_ASSERT_ON
  a_rvalid_expected : assert property (@(posedge clk) disable iff (!rst_n)
    obi_rvalid_i |-> (outstanding_r != 2'd0));
  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state_r == REGISTERED) && !obi_gnt_i |=> (obi_addr_o == $past(obi_addr_o)));
  a_outstanding_max : assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_r <= MAX_OUT);
  a_discard_bound : assert property (@(posedge clk) disable iff (!rst_n)
    discard_r <= outstanding_r);
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_if.sv
// Bench for cv32e40p_instr_obi_if: directed vector table plus randomized traffic
// checked against a queue-based transaction model.
module tb_cv32e40p_instr_obi_if;

  logic        clk;
  logic        rst_n;
  logic        trans_valid_i;
  logic        trans_ready_o;
  logic [31:0] trans_addr_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;
  logic        busy_o;

  cv32e40p_instr_obi_if #(.PULP_OBI(0), .MAX_OUTSTANDING(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trans_valid_i (trans_valid_i),
    .trans_ready_o (trans_ready_o),
    .trans_addr_i  (trans_addr_i),
    .kill_i        (kill_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .obi_req_o     (obi_req_o),
    .obi_gnt_i     (obi_gnt_i),
    .obi_addr_o    (obi_addr_o),
    .obi_rvalid_i  (obi_rvalid_i),
    .obi_rdata_i   (obi_rdata_i),
    .obi_err_i     (obi_err_i),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        tv;
    logic [31:0] ta;
    logic        kill;
    logic        gnt;
    logic        rv;
    logic        err;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_rvld;
    logic        e_busy;
  } vec_t;

  vec_t vt[23];

  // Transaction model: one stale flag per granted request, plus an ungranted held request.
  bit          q[$];
  bit          pend;
  bit          pend_stale;
  logic [31:0] pend_addr;

  task automatic drive_idle();
    trans_valid_i = 1'b0; trans_addr_i = 32'd0; kill_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b0; obi_rdata_i = 32'd0; obi_err_i = 1'b0;
  endtask

  initial begin
    logic m_ready, m_req, m_rvld, m_busy, room, granted, accepted;
    logic [31:0] m_addr;

    // Reset: outputs follow inputs combinationally with all tracking cleared.
    rst_n = 1'b0;
    drive_idle();
    trans_valid_i = 1'b1; obi_rvalid_i = 1'b1;
    #3;
    chk("rst_req", 0, {31'd0, obi_req_o}, 32'd1);
    chk("rst_rvalid", 0, {31'd0, resp_valid_o}, 32'd1);
    chk("rst_busy", 0, {31'd0, busy_o}, 32'd0);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //            tv    ta           kill  gnt   rv    err   ready req   addr         rvld  busy
    vt[0]  = '{1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0084, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 32'h0000_0088, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0088, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 32'h0000_0088, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0088, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 32'h0000_008C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_008C, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b1};
    vt[10] = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1};
    vt[12] = '{1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1};
    vt[13] = '{1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1};
    vt[14] = '{1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 1'b1};
    vt[15] = '{1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 1'b0};
    vt[16] = '{1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0};
    vt[17] = '{1'b1, 32'h0000_0404, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0404, 1'b0, 1'b1};
    vt[18] = '{1'b0, 32'h0000_0404, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0404, 1'b0, 1'b1};
    vt[19] = '{1'b0, 32'h0000_0404, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0404, 1'b0, 1'b1};
    vt[20] = '{1'b1, 32'h0000_0500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0};
    vt[21] = '{1'b0, 32'h0000_0500, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 1'b1, 1'b1};
    vt[22] = '{1'b0, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      trans_valid_i = vt[i].tv;  trans_addr_i = vt[i].ta; kill_i = vt[i].kill;
      obi_gnt_i = vt[i].gnt;     obi_rvalid_i = vt[i].rv; obi_err_i = vt[i].err;
      obi_rdata_i = 32'hD000_0000 + i;
      #1;
      chk("vec_ready", i, {31'd0, trans_ready_o}, {31'd0, vt[i].e_ready});
      chk("vec_req",   i, {31'd0, obi_req_o},     {31'd0, vt[i].e_req});
      chk("vec_addr",  i, obi_addr_o,              vt[i].e_addr);
      chk("vec_rvalid",i, {31'd0, resp_valid_o},  {31'd0, vt[i].e_rvld});
      chk("vec_busy",  i, {31'd0, busy_o},        {31'd0, vt[i].e_busy});
      chk("vec_rdata", i, resp_rdata_o,            32'hD000_0000 + i);
      chk("vec_err",   i, {31'd0, resp_err_o},    {31'd0, vt[i].err});
    end

    // Reset asserted with a transaction in flight abandons all tracking at once.
    @(negedge clk);
    drive_idle();
    trans_valid_i = 1'b1; trans_addr_i = 32'h0000_0600; obi_gnt_i = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    chk("midrst_busy_before", 100, {31'd0, busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_after", 100, {31'd0, busy_o}, 32'd0);
    chk("midrst_req", 100, {31'd0, obi_req_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); pend = 1'b0; pend_stale = 1'b0; pend_addr = 32'd0;

    // Randomized traffic against the transaction model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      trans_valid_i = ($urandom_range(0, 9) < 7);
      trans_addr_i  = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
      kill_i        = ($urandom_range(0, 9) == 0);
      obi_gnt_i     = ($urandom_range(0, 9) < 6);
      obi_rvalid_i  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      obi_rdata_i   = $urandom;
      obi_err_i     = $urandom_range(0, 1);

      room = (q.size() < 2);
      if (pend) begin
        m_req = 1'b1; m_addr = pend_addr; m_ready = 1'b0;
      end else begin
        m_req = trans_valid_i & ~kill_i & room; m_addr = trans_addr_i; m_ready = ~kill_i & room;
      end
      m_rvld = obi_rvalid_i & ~kill_i & ((q.size() > 0) ? ~q[0] : 1'b1);
      m_busy = (q.size() != 0) || pend;

      #1;
      chk("rnd_ready", c, {31'd0, trans_ready_o}, {31'd0, m_ready});
      chk("rnd_req",   c, {31'd0, obi_req_o},     {31'd0, m_req});
      if (m_req) chk("rnd_addr", c, obi_addr_o, m_addr);
      chk("rnd_rvalid",c, {31'd0, resp_valid_o},  {31'd0, m_rvld});
      chk("rnd_busy",  c, {31'd0, busy_o},        {31'd0, m_busy});
      chk("rnd_rdata", c, resp_rdata_o,            obi_rdata_i);
      chk("rnd_err",   c, {31'd0, resp_err_o},    {31'd0, obi_err_i});

      @(posedge clk);
      granted  = m_req & obi_gnt_i;
      accepted = ~pend & m_ready & trans_valid_i;
      if (obi_rvalid_i) void'(q.pop_front());
      if (kill_i) begin
        foreach (q[k]) q[k] = 1'b1;
        if (pend) pend_stale = 1'b1;
      end
      if (granted) begin
        q.push_back(pend ? pend_stale : 1'b0);
        pend = 1'b0; pend_stale = 1'b0;
      end else if (accepted) begin
        pend = 1'b1; pend_addr = trans_addr_i; pend_stale = 1'b0;
      end
    end

    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_obi_if.md
CV32E40P_INSTR_OBI_IF -- requirements
Module: cv32e40p_instr_obi_if

Interface
REQ-001 Parameter PULP_OBI, default 0: 1 = legacy PULP OBI, where the address may change while req is high and not granted.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered OBI transactions (legal range 1..3).
REQ-003 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-004 clk  in  1  core clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 trans_valid_i  in  1  prefetcher requests a fetch.
REQ-007 trans_ready_o  out  1  fetch request accepted this cycle.
REQ-008 trans_addr_i  in  32  word-aligned fetch address.
REQ-009 kill_i  in  1  branch/flush; all in-flight responses become stale.
REQ-010 resp_valid_o  out  1  non-stale response delivered.
REQ-011 resp_rdata_o  out  32  response data.
REQ-012 resp_err_o  out  1  response bus error.
REQ-013 obi_req_o  out  1  OBI request.
REQ-014 obi_gnt_i  in  1  OBI grant.
REQ-015 obi_addr_o  out  32  OBI address.
REQ-016 obi_rvalid_i  in  1  OBI response valid.
REQ-017 obi_rdata_i  in  32  OBI response data.
REQ-018 obi_err_i  in  1  OBI response error.
REQ-019 busy_o  out  1  high when outstanding count != 0 or state == REGISTERED.

Function
REQ-020 The FSM SHALL have two states, TRANSPARENT and REGISTERED; reset state is TRANSPARENT.
REQ-021 TRANSPARENT behaviour:
- obi_req_o = trans_valid_i & !kill_i & (outstanding < MAX_OUTSTANDING).
- obi_addr_o = trans_addr_i.
REQ-022 PULP_OBI=0, TRANSPARENT: trans_ready_o = !kill_i & (outstanding < MAX_OUTSTANDING); an accepted request without obi_gnt_i SHALL latch trans_addr_i and move to REGISTERED.
REQ-023 PULP_OBI=1: REGISTERED is never entered; trans_ready_o = obi_req_o & obi_gnt_i.
REQ-024 REGISTERED behaviour:
- obi_req_o = 1 and obi_addr_o = latched address, held stable every cycle.
- trans_ready_o = 0.
- On obi_gnt_i, return to TRANSPARENT the next cycle; kill_i SHALL NOT retract the request.
REQ-025 The outstanding counter (width 2):
- +1 on obi_req_o & obi_gnt_i; -1 on obi_rvalid_i; unchanged when both occur in the same cycle.
- Reset 0; never exceeds MAX_OUTSTANDING.
REQ-026 On kill_i, the discard counter SHALL load outstanding - obi_rvalid_i + (REGISTERED & obi_gnt_i).
REQ-027 If kill_i occurs in REGISTERED without a grant, a stale flag SHALL set; the later grant of that request increments the discard counter and clears the flag.
REQ-028 A response arriving while the discard counter is non-zero SHALL be dropped (resp_valid_o = 0) and SHALL decrement the discard counter.
- Otherwise resp_valid_o = obi_rvalid_i, combinational, zero latency.
REQ-029 resp_rdata_o = obi_rdata_i and resp_err_o = obi_err_i, unconditionally passed through.
REQ-030 kill_i in the same cycle as a response: that response is counted as answered and is NOT delivered.
REQ-031 Back-to-back requests SHALL be sustained at one per cycle when obi_gnt_i is high and outstanding < MAX_OUTSTANDING.

Reset
REQ-032 On rst_n low, the block SHALL asynchronously reset:
- State to TRANSPARENT.
- Outstanding counter, discard counter and stale flag to 0.
- Latched address to 0.
REQ-033 Output values in reset (combinational, inputs permitting): obi_req_o=0 unless trans_valid_i, resp_valid_o=obi_rvalid_i, busy_o=0.
REQ-034 Reset asserted mid-transaction SHALL abandon all tracking; responses to pre-reset requests are not the block's concern.

Structure
REQ-035 The state enum obi_if_state_e {TRANSPARENT, REGISTERED} SHALL live in cv32e40p_pkg.
REQ-036 No sub-module; a single module of roughly 150-250 lines.
REQ-037 Assertions under CV32E40P_ASSERT_ON:
- obi_rvalid_i implies outstanding != 0.
- obi_addr_o stable in REGISTERED.
- Counters never overflow.

Verification
REQ-038 Stimulus: trans_valid_i=1, addr 0x80, gnt=1 every cycle, rvalid two cycles later. Required: 2 requests/cycles back-to-back, then trans_ready_o=0 until a response; resp_valid_o delivered in order.
REQ-039 Stimulus: PULP_OBI=0, addr 0x100, gnt withheld 3 cycles while trans_addr_i changes to 0x200. Required: obi_addr_o stays 0x100 until gnt; FSM returns to TRANSPARENT.
REQ-040 Stimulus: two outstanding, then kill_i. Required: next two rvalids dropped (resp_valid_o=0); third request's response delivered.
REQ-041 Stimulus: kill_i in REGISTERED without gnt, gnt 2 cycles later. Required: the response to that request is dropped; busy_o falls after it.
REQ-042 Stimulus: kill_i coincident with rvalid, outstanding=2. Required: both responses dropped and the discard counter ends at 0.
REQ-043 Stimulus: obi_err_i=1 with rvalid. Required: resp_err_o=1 with resp_valid_o=1 in the same cycle.
